push_pop_fifo: RTL and testbench

Synchronous FIFO driven by the debounced push-button pulses of the FIFO lab design. It sits directly downstream of the `debounce` instances. One instance's `button_deb` drives `push`, another's drives `pop`, and `din` comes from the board switches. It stores up to 2^DEPTH_LOG2 words and exposes the popped word, the occupancy and status flags for the LEDs/display. It also latches sticky error flags when an operation is rejected.

---
 rtl/push_pop_fifo.sv | 105 ++++++++++
 tb/tb_push_pop_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/push_pop_fifo.sv
// Synchronous FIFO fed by debounced push/pop strobes; registered read port,
// explicit occupancy counter and sticky overflow/underflow flags.
module push_pop_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                ck,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   din,
  input  logic                clear_err,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  always_comb begin
    pop_ok  = pop & ~empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    push_ok = push & (~full | pop_ok);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Rejections are applied after clear so a same-cycle rejection wins.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push && !push_ok) overflow_d  = 1'b1;
    if (pop && !pop_ok)   underflow_d = 1'b1;
  end

  always_ff @(posedge ck) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_push_pop_fifo.sv
// Directed bench for push_pop_fifo: expected pop data goes into a scoreboard
// queue at issue time; a negedge monitor consumes it on every dout_valid.
module tb_push_pop_fifo;

  logic       ck = 1'b0;
  logic       reset;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = 8'h00;
  logic       clear_err = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] count;
  logic       empty, full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  push_pop_fifo #(.DATA_W(8), .DEPTH_LOG2(3)) dut (
    .ck(ck), .reset(reset), .push(push), .pop(pop), .din(din),
    .clear_err(clear_err), .dout(dout), .dout_valid(dout_valid),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every dout_valid pulse must match the oldest expected word.
  always @(negedge ck) begin
    if (dout_valid === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got dout 0x%0h with nothing expected", dout);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL sb_dout: got 0x%0h expected 0x%0h", dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic clr, input logic exp_pop, input logic [7:0] exp_d);
    push = p; pop = q; din = d; clear_err = clr;
    if (exp_pop) sb_q.push_back(exp_d);
    @(posedge ck);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    check("dout_valid", dout_valid, exp_pop);
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", dout, 0);
    check("rst_dvalid", dout_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    @(negedge ck) reset = 1'b1;
    @(posedge ck);
    #1;

    // Fill 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'h11 * (i + 1)), 0, 0, 8'h00);
      check("fill_count", count, i + 1);
    end
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 0);

    // Rejected push on full
    step(1, 0, 8'hAA, 0, 0, 8'h00);
    check("ovf_count", count, 8);
    check("ovf_set", overflow, 1);

    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00, 0, 1, 8'(8'h11 * (i + 1)));
      check("drain_count", count, 7 - i);
    end
    check("drain_empty", empty, 1);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    check("clr_ovf", overflow, 0);

    // Pop on empty
    step(0, 1, 8'h00, 0, 0, 8'h00);
    check("udf_set", underflow, 1);
    check("udf_dout_hold", dout, 8'h88);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    check("clr_udf", underflow, 0);

    // Push+pop on empty: push wins, pop rejected
    step(1, 1, 8'h5C, 0, 0, 8'h00);
    check("pp_empty_count", count, 1);
    check("pp_empty_udf", underflow, 1);
    check("pp_empty_dout", dout, 8'h88);
    step(0, 1, 8'h00, 1, 1, 8'h5C);
    check("pp_empty_drain", count, 0);
    check("pp_empty_clr", underflow, 0);

    // Full simultaneity with pointer wrap
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h11 * (i + 1)), 0, 0, 8'h00);
    check("refill_full", full, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(8'hA0 + i), 0, 1, (i < 8) ? 8'(8'h11 * (i + 1)) : 8'(8'hA0 + i - 8));
      check("pp_full_count", count, 8);
      check("pp_full_ovf", overflow, 0);
    end

    // Set beats clear
    step(1, 0, 8'hBB, 1, 0, 8'h00);
    check("setclr_ovf", overflow, 1);
    check("setclr_count", count, 8);

    for (int i = 2; i < 10; i++) step(0, 1, 8'h00, 0, 1, 8'(8'hA0 + i));
    check("wrap_empty", empty, 1);

    // Reset mid-operation with 5 queued words
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0, 0, 8'h00);
    check("mid_count", count, 5);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_ovf", overflow, 0);
    @(negedge ck) reset = 1'b1;
    @(posedge ck);
    #1;
    step(0, 1, 8'h00, 0, 0, 8'h00);
    check("post_rst_udf", underflow, 1);
    check("post_rst_count", count, 0);

    repeat (2) @(posedge ck);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
